// File: rtl/axis_rr_arbiter.sv
// Packet-aware round-robin arbiter: NUM_PORTS AXI-Stream slaves share one
// registered AXI-Stream master. A grant is held from the first beat of a
// packet until its tlast beat is accepted; every beat is tagged with its
// source port index on m_axis_tid.
module axis_rr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PORTS  = 4,
  parameter int ID_WIDTH   = 2
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  output logic [NUM_PORTS-1:0]            s_axis_tready,
  input  logic [NUM_PORTS-1:0]            s_axis_tlast,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic [ID_WIDTH-1:0]             m_axis_tid
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  // Reset value of the round-robin pointer so that port 0 wins first.
  localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(NUM_PORTS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                 state_q;
  logic [IDX_W-1:0]       grant_q;
  logic [IDX_W-1:0]       last_q;
  logic [IDX_W-1:0]       pick_d;
  logic                   pick_valid_d;

  logic [DATA_WIDTH-1:0]  tdata_q;
  logic                   tvalid_q;
  logic                   tlast_q;
  logic [ID_WIDTH-1:0]    tid_q;

  logic [DATA_WIDTH-1:0]  port_data [NUM_PORTS];
  logic                   out_free;
  logic                   sel_valid;
  logic                   sel_last;
  logic                   slave_accept;

  // The output register can take a new beat when empty or being drained.
  assign out_free = !tvalid_q || m_axis_tready;

  // Per-port data unpacking and ready generation. Ready depends only on
  // registered state and m_axis_tready, never on any s_axis_tvalid.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    assign port_data[gi]     = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
    assign s_axis_tready[gi] = (state_q == BUSY) && (grant_q == IDX_W'(gi)) && out_free;
  end

  assign sel_valid    = s_axis_tvalid[grant_q];
  assign sel_last     = s_axis_tlast[grant_q];
  assign slave_accept = (state_q == BUSY) && sel_valid && out_free;

  // Round-robin search: first requester scanning upward from last_q+1.
  always_comb begin
    int cand_i;
    pick_d       = last_q;
    pick_valid_d = 1'b0;
    cand_i       = 0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand_i = (int'(last_q) + k) % NUM_PORTS;
      if (!pick_valid_d && s_axis_tvalid[IDX_W'(cand_i)]) begin
        pick_valid_d = 1'b1;
        pick_d       = IDX_W'(cand_i);
      end
    end
  end

  // Grant FSM: lock onto the picked port until its tlast beat is taken.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LAST_PORT;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid_d) begin
            state_q <= BUSY;
            grant_q <= pick_d;
            last_q  <= pick_d;
          end
        end
        BUSY: begin
          if (slave_accept && sel_last) begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  // Output register: a new beat replaces the old one; otherwise a master
  // handshake empties it. Payload holds while stalled.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      tid_q    <= '0;
    end else if (slave_accept) begin
      tvalid_q <= 1'b1;
      tdata_q  <= port_data[grant_q];
      tlast_q  <= sel_last;
      tid_q    <= ID_WIDTH'(grant_q);
    end else if (m_axis_tready) begin
      tvalid_q <= 1'b0;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tid    = tid_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Self-checking bench for axis_rr_arbiter: directed scenarios plus random
// traffic, compared every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_axis_rr_arbiter;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  typedef struct {
    int            tid;
    logic [DW-1:0] data;
    logic          last;
    int            cyc;
  } log_t;

  logic             aclk = 1'b0;
  logic             aresetn;
  logic [NP*DW-1:0] s_axis_tdata;
  logic [NP-1:0]    s_axis_tvalid;
  logic [NP-1:0]    s_axis_tready;
  logic [NP-1:0]    s_axis_tlast;
  logic [DW-1:0]    m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tready;
  logic             m_axis_tlast;
  logic [IW-1:0]    m_axis_tid;

  always #5 aclk = ~aclk;

  axis_rr_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_PORTS  (NP),
    .ID_WIDTH   (IW)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tid    (m_axis_tid)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;

  beat_t src_q [NP][$];
  beat_t exp_q [NP][$];
  int    pause_sz   [NP];
  int    pause_left [NP];
  int    vprob = 100;
  int    mprob = 100;
  bit    mr_pat [$];
  log_t  out_log [$];

  // Behavioural model state: who owns the output, round-robin pointer,
  // and the content of the single output slot.
  int            m_owner = -1;
  int            m_last  = NP - 1;
  bit            m_full  = 1'b0;
  logic [DW-1:0] m_data  = '0;
  logic          m_tlast = 1'b0;
  int            m_tid   = 0;

  bit            p_valid = 1'b0;
  bit            p_ready = 1'b0;
  logic [DW-1:0] p_data  = '0;
  logic [IW-1:0] p_tid   = '0;
  logic          p_last  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the model, then advance the model.
  always @(negedge aclk) begin
    logic [NP-1:0] exp_rdy;
    bit            acc;
    int            n_owner;
    int            c;
    log_t          e;
    cyc++;
    if (!aresetn) begin
      check("rst_tvalid", m_axis_tvalid, 0);
      check("rst_tdata", m_axis_tdata, 0);
      check("rst_tlast", m_axis_tlast, 0);
      check("rst_tid", m_axis_tid, 0);
      check("rst_tready", s_axis_tready, 0);
      m_owner = -1;
      m_last  = NP - 1;
      m_full  = 1'b0;
      m_data  = '0;
      m_tlast = 1'b0;
      m_tid   = 0;
      p_valid = 1'b0;
    end else begin
      exp_rdy = '0;
      if (m_owner >= 0 && (!m_full || m_axis_tready)) exp_rdy[m_owner] = 1'b1;
      check("tready", s_axis_tready, exp_rdy);
      check("tvalid", m_axis_tvalid, m_full);
      if (m_full) begin
        check("tdata", m_axis_tdata, m_data);
        check("tlast", m_axis_tlast, m_tlast);
        check("tid", m_axis_tid, m_tid);
      end
      if (p_valid && !p_ready) begin
        check("hold_tdata", m_axis_tdata, p_data);
        check("hold_tid", m_axis_tid, p_tid);
        check("hold_tlast", m_axis_tlast, p_last);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        e.tid  = int'(m_axis_tid);
        e.data = m_axis_tdata;
        e.last = m_axis_tlast;
        e.cyc  = cyc;
        out_log.push_back(e);
        $display("beat cyc=%0d tid=%0d data=%08h last=%0d", cyc, e.tid, e.data, e.last);
      end
      p_valid = m_axis_tvalid;
      p_ready = m_axis_tready;
      p_data  = m_axis_tdata;
      p_tid   = m_axis_tid;
      p_last  = m_axis_tlast;

      acc     = (m_owner >= 0) && s_axis_tvalid[m_owner] && exp_rdy[m_owner];
      n_owner = m_owner;
      if (m_owner < 0) begin
        for (int k = 1; k <= NP; k++) begin
          c = (m_last + k) % NP;
          if (n_owner < 0 && s_axis_tvalid[c]) n_owner = c;
        end
        if (n_owner >= 0) m_last = n_owner;
      end else if (acc && s_axis_tlast[m_owner]) begin
        n_owner = -1;
      end
      if (acc) begin
        m_full  = 1'b1;
        m_data  = s_axis_tdata[m_owner*DW +: DW];
        m_tlast = s_axis_tlast[m_owner];
        m_tid   = m_owner;
      end else if (m_axis_tready) begin
        m_full = 1'b0;
      end
      m_owner = n_owner;
    end
  end

  // One clock of stimulus: retire accepted beats, then drive the next ones.
  task automatic cycle();
    beat_t b;
    bit    v;
    @(negedge aclk);
    for (int p = 0; p < NP; p++) begin
      if (aresetn && s_axis_tvalid[p] && s_axis_tready[p]) b = src_q[p].pop_front();
    end
    @(posedge aclk);
    #1;
    for (int p = 0; p < NP; p++) begin
      v = 1'b0;
      if (src_q[p].size() > 0) begin
        if (pause_left[p] > 0 && src_q[p].size() == pause_sz[p]) pause_left[p]--;
        else if ($urandom_range(99) < vprob) v = 1'b1;
      end
      s_axis_tvalid[p] = v;
      if (v) begin
        s_axis_tdata[p*DW +: DW] = src_q[p][0].data;
        s_axis_tlast[p]          = src_q[p][0].last;
      end else begin
        s_axis_tdata[p*DW +: DW] = '0;
        s_axis_tlast[p]          = 1'b0;
      end
    end
    if (mr_pat.size() > 0) m_axis_tready = mr_pat.pop_front();
    else m_axis_tready = ($urandom_range(99) < mprob);
  endtask

  task automatic push_pkt(input int p, input logic [DW-1:0] base, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = base + DW'(i);
      b.last = (i == len - 1);
      src_q[p].push_back(b);
      exp_q[p].push_back(b);
    end
  endtask

  function automatic bit pending();
    bit r;
    r = 1'b0;
    for (int p = 0; p < NP; p++) if (src_q[p].size() > 0) r = 1'b1;
    return r;
  endfunction

  task automatic run_until_empty(input int budget, input string name);
    int n;
    n = 0;
    while ((pending() || m_axis_tvalid) && n < budget) begin
      cycle();
      n++;
    end
    check({"bound_", name}, n < budget, 1);
  endtask

  // Reset asserted between clock edges; outputs must drop at once.
  task automatic do_reset();
    @(posedge aclk);
    #3;
    aresetn = 1'b0;
    #1;
    check("async_rst_tvalid", m_axis_tvalid, 0);
    check("async_rst_tready", s_axis_tready, 0);
    cycle();
    cycle();
    aresetn = 1'b1;
  endtask

  initial begin
    int   n;
    int   t;
    beat_t b;
    aresetn       = 1'b0;
    s_axis_tvalid = '0;
    s_axis_tdata  = '0;
    s_axis_tlast  = '0;
    m_axis_tready = 1'b0;
    for (int p = 0; p < NP; p++) begin
      pause_sz[p]   = 0;
      pause_left[p] = 0;
    end
    repeat (3) cycle();
    aresetn = 1'b1;

    // Single 4-beat packet from port 2.
    out_log.delete();
    for (int i = 0; i < 4; i++) begin
      b.data = 32'hA0 + DW'(i);
      b.last = (i == 3);
      src_q[2].push_back(b);
    end
    run_until_empty(50, "t1");
    check("t1_count", out_log.size(), 4);
    for (int j = 0; j < out_log.size() && j < 4; j++) begin
      check("t1_data", out_log[j].data, 32'hA0 + j);
      check("t1_tid", out_log[j].tid, 2);
      check("t1_last", out_log[j].last, (j == 3));
      if (j > 0) check("t1_gap", out_log[j].cyc - out_log[j-1].cyc, 1);
    end

    // Fairness: all ports offer three 2-beat packets each.
    do_reset();
    out_log.delete();
    for (int k = 0; k < 3; k++)
      for (int p = 0; p < NP; p++)
        push_pkt(p, 32'hB000_0000 | (p << 8) | (k << 4), 2);
    run_until_empty(200, "t2");
    check("t2_count", out_log.size(), 24);
    for (int j = 0; j < out_log.size(); j++) begin
      check("t2_tid", out_log[j].tid, (j / 2) % NP);
      check("t2_last", out_log[j].last, j % 2);
      if (j > 0) check("t2_gap", out_log[j].cyc - out_log[j-1].cyc, (j % 2 == 1) ? 1 : 2);
    end

    // Packet lock: port 0 pauses after 3 of 6 beats while port 1 waits.
    do_reset();
    out_log.delete();
    push_pkt(0, 32'hC0, 6);
    push_pkt(1, 32'hD0, 2);
    pause_sz[0]   = 3;
    pause_left[0] = 5;
    n = 0;
    while ((pending() || m_axis_tvalid) && n < 200) begin
      cycle();
      n++;
      #1;
      if (src_q[0].size() > 0) check("t3_lock_rdy1", s_axis_tready[1], 0);
    end
    check("bound_t3", n < 200, 1);
    check("t3_paused", pause_left[0], 0);
    check("t3_count", out_log.size(), 8);
    for (int j = 0; j < out_log.size() && j < 8; j++)
      check("t3_tid", out_log[j].tid, (j < 6) ? 0 : 1);

    // Backpressure during an 8-beat packet.
    do_reset();
    out_log.delete();
    push_pkt(3, 32'hE0, 8);
    mr_pat = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    run_until_empty(100, "t4");
    check("t4_count", out_log.size(), 8);
    for (int j = 0; j < out_log.size() && j < 8; j++) begin
      check("t4_data", out_log[j].data, 32'hE0 + j);
      check("t4_tid", out_log[j].tid, 3);
    end

    // Wrap-around: port 3 goes last, then ports 0 and 2 compete.
    do_reset();
    out_log.delete();
    push_pkt(3, 32'hF3, 1);
    run_until_empty(50, "t5a");
    push_pkt(0, 32'hF0, 1);
    push_pkt(2, 32'hF2, 1);
    run_until_empty(50, "t5b");
    check("t5_count", out_log.size(), 3);
    if (out_log.size() == 3) begin
      check("t5_tid0", out_log[0].tid, 3);
      check("t5_tid1", out_log[1].tid, 0);
      check("t5_tid2", out_log[2].tid, 2);
    end

    // Reset while port 1 holds a beat on the master side.
    do_reset();
    mprob = 0;
    push_pkt(1, 32'h10, 4);
    n = 0;
    while (!m_axis_tvalid && n < 20) begin
      cycle();
      n++;
    end
    check("bound_t6", n < 20, 1);
    check("t6_held_tid", m_axis_tid, 1);
    push_pkt(3, 32'h30, 2);
    mprob = 100;
    out_log.delete();
    do_reset();
    run_until_empty(100, "t6");
    check("t6_count", out_log.size(), 5);
    if (out_log.size() > 0) begin
      check("t6_first_tid", out_log[0].tid, 1);
      check("t6_first_data", out_log[0].data, 32'h11);
    end

    // Random traffic with random valid gaps and backpressure.
    for (int p = 0; p < NP; p++) exp_q[p].delete();
    out_log.delete();
    vprob = 75;
    mprob = 70;
    for (int i = 0; i < 1500; i++) begin
      for (int p = 0; p < NP; p++)
        if (src_q[p].size() == 0 && $urandom_range(3) == 0)
          push_pkt(p, $urandom, $urandom_range(1, 6));
      cycle();
    end
    vprob = 100;
    mprob = 100;
    run_until_empty(300, "t7");
    for (int j = 0; j < out_log.size(); j++) begin
      t = out_log[j].tid;
      if (j > 0 && !out_log[j-1].last) check("t7_interleave", t, out_log[j-1].tid);
      if (exp_q[t].size() == 0) begin
        check("t7_extra_beat", 1, 0);
      end else begin
        b = exp_q[t].pop_front();
        check("t7_data", out_log[j].data, b.data);
        check("t7_last", out_log[j].last, b.last);
      end
    end
    for (int p = 0; p < NP; p++) check("t7_missing", exp_q[p].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
